// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t     : arbiter FSM encoding (idle, response pending on port 0 / 1)
//   PORT0/PORT1 : requester index constants used by the grant logic
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESP0 = 2'd1,
    ST_RESP1 = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector.
//   req0, req1 : request lines
//   rr         : preferred port when both request
//   gnt_any    : at least one request present
//   gnt_port   : index of the selected port (meaningful when gnt_any)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic gnt_any,
  output logic gnt_port
);

  always_comb begin
    gnt_any  = req0 | req1;
    gnt_port = PORT0;
    if (req0 && req1) begin
      gnt_port = rr;
    end else if (req1) begin
      gnt_port = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory with a
// combinational read path. One request is accepted per IDLE cycle; the
// response (read data, or zero for a write) is held in a per-port register
// until the owner consumes it, then the FSM returns to IDLE.
//   clk, reset             : clock, synchronous active-high reset
//   pN_req_*               : requester N request channel (valid/ready)
//   pN_rsp_*               : requester N response channel (valid/ready)
//   mem_*                  : data memory control, address, write/read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p0_req_valid,
  input  logic                      p0_req_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0]     p0_req_wdata,
  output logic                      p0_req_ready,
  output logic                      p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]     p0_rsp_rdata,
  input  logic                      p0_rsp_ready,
  input  logic                      p1_req_valid,
  input  logic                      p1_req_we,
  input  logic [MEM_ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0]     p1_req_wdata,
  output logic                      p1_req_ready,
  output logic                      p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]     p1_rsp_rdata,
  input  logic                      p1_rsp_ready,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_write_data,
  input  logic [DATA_WIDTH-1:0]     mem_read_data
);

  state_t                      state_q;
  state_t                      state_d;
  logic                        rr_q;
  logic                        arb_any;
  logic                        gnt_port_p0;
  logic                        grant_p0;
  logic                        sel_we_p0;
  logic [MEM_ADDR_WIDTH-1:0]   sel_addr_p0;
  logic [DATA_WIDTH-1:0]       sel_wdata_p0;
  logic [DATA_WIDTH-1:0]       rsp_rdata0_p1;
  logic [DATA_WIDTH-1:0]       rsp_rdata1_p1;

  // ---- stage p0: grant selection and memory access ----
  rr_arb2 u_rr_arb2 (
    .req0     (p0_req_valid),
    .req1     (p1_req_valid),
    .rr       (rr_q),
    .gnt_any  (arb_any),
    .gnt_port (gnt_port_p0)
  );

  // Gating with reset keeps ready and mem_write_en low in a reset cycle,
  // so a request coinciding with reset never commits a write.
  assign grant_p0     = (state_q == ST_IDLE) && !reset && arb_any;
  assign sel_we_p0    = (gnt_port_p0 == PORT1) ? p1_req_we    : p0_req_we;
  assign sel_addr_p0  = (gnt_port_p0 == PORT1) ? p1_req_addr  : p0_req_addr;
  assign sel_wdata_p0 = (gnt_port_p0 == PORT1) ? p1_req_wdata : p0_req_wdata;

  always_comb begin
    state_d        = state_q;
    p0_req_ready   = 1'b0;
    p1_req_ready   = 1'b0;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (grant_p0) begin
      p0_req_ready   = (gnt_port_p0 == PORT0);
      p1_req_ready   = (gnt_port_p0 == PORT1);
      mem_read_en    = ~sel_we_p0;
      mem_write_en   = sel_we_p0;
      mem_address    = sel_addr_p0;
      mem_write_data = sel_wdata_p0;
    end
    case (state_q)
      ST_IDLE: begin
        if (grant_p0) begin
          state_d = (gnt_port_p0 == PORT1) ? ST_RESP1 : ST_RESP0;
        end
      end
      ST_RESP0: if (p0_rsp_ready) state_d = ST_IDLE;
      ST_RESP1: if (p1_rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- stage p1: response registers, held until consumed ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_q          <= PORT0;
      rsp_rdata0_p1 <= '0;
      rsp_rdata1_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (grant_p0) begin
        rr_q <= ~gnt_port_p0;
        if (gnt_port_p0 == PORT0) begin
          rsp_rdata0_p1 <= sel_we_p0 ? '0 : mem_read_data;
        end else begin
          rsp_rdata1_p1 <= sel_we_p0 ? '0 : mem_read_data;
        end
      end
    end
  end

  assign p0_rsp_valid = (state_q == ST_RESP0);
  assign p1_rsp_valid = (state_q == ST_RESP1);
  assign p0_rsp_rdata = rsp_rdata0_p1;
  assign p1_rsp_rdata = rsp_rdata1_p1;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data word width of the memory and of all data ports.
REQ-002 Parameter MEM_ADDR_WIDTH, default 10, word-address width of the memory and of all address ports.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 pN_req_valid  in  1  requester N (N=0,1) presents a memory request.
REQ-006 pN_req_we  in  1  requester N request type: 1 = write, 0 = read.
REQ-007 pN_req_addr  in  MEM_ADDR_WIDTH  requester N word address.
REQ-008 pN_req_wdata  in  DATA_WIDTH  requester N write data.
REQ-009 pN_req_ready  out  1  requester N request accepted this cycle.
REQ-010 pN_rsp_valid  out  1  response for requester N is pending.
REQ-011 pN_rsp_rdata  out  DATA_WIDTH  read data for requester N; zero for write responses.
REQ-012 pN_rsp_ready  in  1  requester N consumes its response.
REQ-013 mem_read_en  out  1  drives the data memory read enable.
REQ-014 mem_write_en  out  1  drives the data memory write enable.
REQ-015 mem_address  out  MEM_ADDR_WIDTH  drives the data memory address.
REQ-016 mem_write_data  out  DATA_WIDTH  drives the data memory write data.
REQ-017 mem_read_data  in  DATA_WIDTH  combinational read data returned by the memory.

Function
REQ-018 The FSM SHALL have the states IDLE, RESP0 and RESP1.
REQ-019 In IDLE with exactly one pN_req_valid high, the block SHALL grant port N; with both high, it SHALL grant the port indicated by the round-robin pointer rr.
REQ-020 A grant SHALL assert the granted pN_req_ready combinationally in the same cycle; that signal SHALL never be high outside IDLE, and the other port's ready SHALL stay low.
REQ-021 During the grant cycle, mem_address and mem_write_data SHALL equal the granted port's inputs, and mem_write_en = pN_req_we and mem_read_en = ~pN_req_we.
REQ-022 Outside a grant cycle, all mem_* outputs SHALL be zero.
REQ-023 On a read grant, mem_read_data SHALL be captured into pN_rsp_rdata at the grant edge.
REQ-024 On a write grant, the memory write SHALL occur at the grant edge and pN_rsp_rdata SHALL be loaded with zero.
REQ-025 At the grant edge, the FSM SHALL enter RESPN and rr SHALL point to the non-granted port.
REQ-026 pN_rsp_valid SHALL be high exactly while in RESPN, giving a response latency of one cycle after acceptance.
REQ-027 pN_rsp_rdata SHALL stay stable while pN_rsp_valid is high.
REQ-028 In RESPN with pN_rsp_ready high, the FSM SHALL return to IDLE at the next edge; otherwise it SHALL remain in RESPN indefinitely.
REQ-029 Requests arriving while in RESPx SHALL wait unaccepted, and requesters SHALL hold their request signals stable until ready.
REQ-030 Sustained throughput SHALL be at most one access per two cycles, and a continuously requesting port SHALL be granted within two accesses.

Reset
REQ-031 Reset SHALL force: state IDLE, rr = 0 (port 0 preferred), pN_rsp_valid = 0, pN_rsp_rdata = 0, and pN_req_ready = 0 during the reset cycle.
REQ-032 Reset asserted in RESPN SHALL drop the pending response without a handshake.
REQ-033 Reset asserted in a grant cycle SHALL suppress mem_write_en for that cycle, so no write is committed.

Structure
REQ-034 The FSM state encoding and the port-index constants SHALL reside in the shared package dmem_pkg.
REQ-035 The block SHALL be a single module; the two-input round-robin selector MAY be factored as sub-module rr_arb2.

Verification
REQ-036 Port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> p0_rsp_valid rises one cycle after each accept, and the read returns 0xDEADBEEF.
REQ-037 Both ports request reads from reset, continuously -> grants alternate 0, 1, 0, 1, and each port is served exactly once per four cycles.
REQ-038 p1_rsp_ready held low for 10 cycles -> p1_rsp_valid and p1_rsp_rdata are stable, and p0_req_ready stays 0 throughout.
REQ-039 Reset pulsed during RESP0 -> after reset, p0_rsp_valid = 0 and state is IDLE, and the next dual request grants port 0.
REQ-040 Reset coincident with a write grant to addr 3 (previously 0x1) -> mem_write_en = 0 and a later read of addr 3 returns 0x1.
REQ-041 No requests for 20 cycles -> all mem_* outputs are 0 and no rsp_valid is asserted.
